// File: rtl/tow_pkg.sv
// Shared types and constants for the Tug of War referee.
package tow_pkg;
    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        HOLD       = 2'd1,
        MATCH_OVER = 2'd2
    } ref_state_t;

    localparam logic [1:0] NO_WIN = 2'b00;
    localparam logic [1:0] P1_WIN = 2'b01;
    localparam logic [1:0] P2_WIN = 2'b10;

    localparam int SCORE_W = 4;
endpackage

// File: rtl/tow_score_counter.sv
// Per-player round counter: increments on a round win and saturates at WIN_SCORE.
module tow_score_counter
    import tow_pkg::*;
#(
    parameter int WIN_SCORE = 7
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count < SCORE_W'(WIN_SCORE))) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tow_referee.sv
// Round/match controller: moves the rope light, awards rounds, holds the display,
// and ends the match when a player reaches WIN_SCORE.
module tow_referee
    import tow_pkg::*;
#(
    parameter int NUM_LIGHTS  = 9,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  press1,
    input  logic                  press2,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]    score1,
    output logic [SCORE_W-1:0]    score2,
    output logic [1:0]            round_win,
    output logic                  match_over
);

    localparam int PW = $clog2(NUM_LIGHTS);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW-1:0] CENTER = PW'((NUM_LIGHTS - 1) / 2);
    localparam logic [PW-1:0] LAST   = PW'(NUM_LIGHTS - 1);
    localparam logic [NUM_LIGHTS-1:0] ONE = NUM_LIGHTS'(1);

    ref_state_t            state_q, state_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [NUM_LIGHTS-1:0] lights_d;
    logic [1:0]            round_win_d;
    logic                  match_over_d;
    logic                  inc1, inc2;
    logic [SCORE_W-1:0]    winner_score;

    // Scores are already updated by the time HOLD expires, so compare the stored value.
    assign winner_score = (round_win == P1_WIN) ? score1 : score2;

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        hold_d       = hold_q;
        lights_d     = lights;
        round_win_d  = round_win;
        match_over_d = match_over;
        inc1         = 1'b0;
        inc2         = 1'b0;

        case (state_q)
            PLAY: begin
                if (press1 && !press2) begin
                    if (pos_q == '0) begin
                        inc1        = 1'b1;
                        round_win_d = P1_WIN;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end else if (press2 && !press1) begin
                    if (pos_q == LAST) begin
                        inc2        = 1'b1;
                        round_win_d = P2_WIN;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end

                if (inc1 || inc2) begin
                    state_d  = HOLD;
                    hold_d   = HW'(HOLD_CYCLES - 1);
                    lights_d = '0;
                end else begin
                    lights_d = ONE << pos_d;
                end
            end

            HOLD: begin
                lights_d = '0;
                if (hold_q == '0) begin
                    if (winner_score == SCORE_W'(WIN_SCORE)) begin
                        state_d      = MATCH_OVER;
                        match_over_d = 1'b1;
                    end else begin
                        state_d     = PLAY;
                        pos_d       = CENTER;
                        round_win_d = NO_WIN;
                        lights_d    = ONE << CENTER;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            MATCH_OVER: begin
                lights_d = '0;
            end

            default: begin
                state_d = PLAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PLAY;
            pos_q      <= CENTER;
            hold_q     <= '0;
            lights     <= ONE << CENTER;
            round_win  <= NO_WIN;
            match_over <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            hold_q     <= hold_d;
            lights     <= lights_d;
            round_win  <= round_win_d;
            match_over <= match_over_d;
        end
    end

    tow_score_counter #(.WIN_SCORE(WIN_SCORE)) u_score1 (
        .clk   (clk),
        .clear (reset),
        .inc   (inc1),
        .count (score1)
    );

    tow_score_counter #(.WIN_SCORE(WIN_SCORE)) u_score2 (
        .clk   (clk),
        .clear (reset),
        .inc   (inc2),
        .count (score2)
    );

endmodule
